// File: rtl/act_vec_loader_if.sv
// Streaming-in / vector-out bundle for the activation loader.
// The slave modport is the loader; master is the producer plus the layer consumer.
interface act_vec_loader_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN    = 400
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic             err_len;

    modport master (
        output s_data, s_valid, s_last, x_ready,
        input  s_ready, x, x_valid, err_len
    );

    modport slave (
        input  s_data, s_valid, s_last, x_ready,
        output s_ready, x, x_valid, err_len
    );
endinterface

// File: rtl/act_vec_loader.sv
// Ping-pong activation loader: packs a serial word stream into IN-word vectors
// and holds each complete vector for the downstream layer until it is consumed.
module act_vec_loader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN    = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    act_vec_loader_if.slave  bus
);
    localparam int unsigned CW = (IN > 1) ? $clog2(IN) : 1;

    logic [WIDTH-1:0] bank [0:1][0:IN-1];
    logic [1:0]       full, full_d;
    logic             wsel, wsel_d;
    logic             rsel, rsel_d;
    logic [CW-1:0]    wcnt, wcnt_d;
    logic             err_q, err_d;

    logic accept;
    logic at_end;
    logic consume;

    assign accept  = bus.s_valid && !full[wsel];
    assign at_end  = (wcnt == CW'(IN - 1));
    assign consume = full[rsel] && bus.x_ready;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 2'b00;
            wsel  <= 1'b0;
            rsel  <= 1'b0;
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            full  <= full_d;
            wsel  <= wsel_d;
            rsel  <= rsel_d;
            wcnt  <= wcnt_d;
            err_q <= err_d;
        end
    end

    // Next-state: consume and commit always target different banks, so both may apply
    always_comb begin
        full_d = full;
        wsel_d = wsel;
        rsel_d = rsel;
        wcnt_d = wcnt;
        err_d  = 1'b0;

        if (consume) begin
            full_d[rsel] = 1'b0;
            rsel_d       = !rsel;
        end

        if (accept) begin
            if (at_end) begin
                // A missing last still commits; only the error is flagged
                full_d[wsel] = 1'b1;
                wsel_d       = !wsel;
                wcnt_d       = '0;
                err_d        = !bus.s_last;
            end else if (bus.s_last) begin
                wcnt_d = '0;
                err_d  = 1'b1;
            end else begin
                wcnt_d = wcnt + CW'(1);
            end
        end
    end

    // Bank storage; an aborted frame is simply overwritten by the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(IN); i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (accept) begin
            bank[wsel][wcnt] <= bus.s_data;
        end
    end

    assign bus.s_ready = !full[wsel];
    assign bus.x_valid = full[rsel];
    assign bus.x       = bank[rsel];
    assign bus.err_len = err_q;
endmodule

// File: tb/tb_act_vec_loader.sv
// Directed self-checking bench for act_vec_loader using IN=400, WIDTH=8.
module tb_act_vec_loader;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IN    = 400;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   err_cnt;
    int   cyc;

    act_vec_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

    act_vec_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.err_len === 1'b1) err_cnt <= err_cnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame f, word i (0-based); frame 0 reproduces word k = k mod 256
    function automatic logic [7:0] pat(input int f, input int i);
        return 8'((i + 1) + f * 37);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, output int waited);
        waited = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = l;
        while (!bus.s_ready && waited < 2000) begin
            tick();
            waited++;
        end
        if (!bus.s_ready) chk("send_timeout", 1, 0);
        else tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int f, input int n, input logic with_last, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            send(pat(f, i), with_last && (i == n - 1), w);
            waits += w;
        end
    endtask

    task automatic consume(input int f);
        chk("cons_valid", int'(bus.x_valid), 1);
        chk("cons_x0",    int'(bus.x[0]),      int'(pat(f, 0)));
        chk("cons_xmid",  int'(bus.x[IN/2]),   int'(pat(f, IN/2)));
        chk("cons_xlast", int'(bus.x[IN-1]),   int'(pat(f, IN-1)));
        bus.x_ready = 1'b1;
        tick();
        bus.x_ready = 1'b0;
    endtask

    initial begin
        int waits;
        int stable;
        int t0;
        int k;
        n_checks = 0;
        n_fail   = 0;
        err_cnt  = 0;
        cyc      = 0;
        rst_n       = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.x_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready", int'(bus.s_ready), 1);
        chk("rst_x_valid", int'(bus.x_valid), 0);
        chk("rst_err_len", int'(bus.err_len), 0);
        chk("rst_x0",      int'(bus.x[0]),    0);
        tick();

        // Single frame, held for 50 cycles
        send_frame(0, IN, 1'b1, waits);
        chk("single_valid", int'(bus.x_valid), 1);
        chk("single_x0",    int'(bus.x[0]),    1);
        chk("single_x255",  int'(bus.x[255]),  0);
        chk("single_x399",  int'(bus.x[399]),  144);
        stable = 1;
        repeat (50) begin
            tick();
            if (bus.x_valid !== 1'b1 || bus.x[0] !== 8'd1 || bus.x[399] !== 8'd144) stable = 0;
        end
        chk("single_hold", stable, 1);
        consume(0);
        chk("single_freed", int'(bus.x_valid), 0);
        chk("single_no_err", err_cnt, 0);

        // Back-to-back, downstream stalled
        send_frame(1, IN, 1'b1, waits);
        chk("b2b_f1_waits", waits, 0);
        send_frame(2, IN, 1'b1, waits);
        chk("b2b_f2_waits", waits, 0);
        chk("b2b_full_ready", int'(bus.s_ready), 0);
        bus.s_data  = pat(3, 0);
        bus.s_valid = 1'b1;
        repeat (5) tick();
        chk("b2b_stall_ready", int'(bus.s_ready), 0);
        chk("b2b_stall_x0",    int'(bus.x[0]),    int'(pat(1, 0)));
        bus.x_ready = 1'b1;
        tick();
        bus.x_ready = 1'b0;
        chk("b2b_swap_valid", int'(bus.x_valid), 1);
        chk("b2b_swap_x0",    int'(bus.x[0]),    int'(pat(2, 0)));
        chk("b2b_swap_x399",  int'(bus.x[399]),  int'(pat(2, 399)));
        chk("b2b_swap_ready", int'(bus.s_ready), 1);
        send_frame(3, IN, 1'b1, waits);
        consume(2);
        consume(3);
        chk("b2b_drained", int'(bus.x_valid), 0);

        // Continuous throughput with x_ready held high
        bus.x_ready = 1'b1;
        t0 = cyc;
        k  = 0;
        fork
            begin
                int tw;
                tw = 0;
                for (int f = 10; f < 20; f++) begin
                    send_frame(f, IN, 1'b1, waits);
                    tw += waits;
                end
                chk("tp_waits",  tw, 0);
                chk("tp_cycles", cyc - t0, 10 * IN);
            end
            begin
                int budget;
                budget = 0;
                while (k < 10 && budget < 6000) begin
                    tick();
                    budget++;
                    if (bus.x_valid === 1'b1) begin
                        chk("tp_x0",   int'(bus.x[0]),   int'(pat(10 + k, 0)));
                        chk("tp_x399", int'(bus.x[399]), int'(pat(10 + k, 399)));
                        k++;
                    end
                end
            end
        join
        chk("tp_handshakes", k, 10);
        tick();
        bus.x_ready = 1'b0;
        chk("tp_no_err", err_cnt, 0);
        chk("tp_drained", int'(bus.x_valid), 0);

        // Early last on word 100
        err_cnt = 0;
        send_frame(20, 100, 1'b1, waits);
        chk("early_err_pulse", int'(bus.err_len), 1);
        tick();
        chk("early_err_clear", int'(bus.err_len), 0);
        chk("early_no_valid",  int'(bus.x_valid), 0);
        send_frame(21, IN, 1'b1, waits);
        chk("early_next_valid", int'(bus.x_valid), 1);
        chk("early_next_x150",  int'(bus.x[150]),  int'(pat(21, 150)));
        chk("early_err_count",  err_cnt, 1);
        consume(21);

        // Missing last
        err_cnt = 0;
        send_frame(22, IN, 1'b0, waits);
        chk("miss_valid",     int'(bus.x_valid), 1);
        chk("miss_err_pulse", int'(bus.err_len), 1);
        send_frame(23, IN, 1'b1, waits);
        consume(22);
        consume(23);
        chk("miss_err_count", err_cnt, 1);

        // Reset with one vector held and a partial frame in flight
        err_cnt = 0;
        send_frame(24, IN, 1'b1, waits);
        send_frame(25, 250, 1'b0, waits);
        chk("rstm_pre_valid", int'(bus.x_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_x_valid", int'(bus.x_valid), 0);
        chk("rstm_s_ready", int'(bus.s_ready), 1);
        chk("rstm_x0",      int'(bus.x[0]),    0);
        chk("rstm_x399",    int'(bus.x[399]),  0);
        chk("rstm_err_len", int'(bus.err_len), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstm_err_count", err_cnt, 0);
        send_frame(26, IN, 1'b1, waits);
        consume(26);
        chk("rstm_final_idle", int'(bus.x_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
